// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces raw push-buttons into level, press and release signals
module button_conditioner #(
    parameter int WIDTH        = 4,
    parameter int STABLE_COUNT = 1000000,
    parameter int CNT_W        = 20
) (
    input  logic             x1,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_level,
    output logic [WIDTH-1:0] buttons_press,
    output logic [WIDTH-1:0] buttons_release,
    output logic             any_pressed
);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    logic [WIDTH-1:0] r_sync1, r_sync2;
    logic [WIDTH-1:0] w_level_nxt;

    // two-flop synchronizer; only the second stage feeds the debouncers
    always_ff @(posedge x1 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= buttons_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level, r_press, r_release;
        logic             w_done;

        assign w_done = r_cnt == CNT_W'(STABLE_COUNT - 1);
        assign w_level_nxt[g] = (r_state == CHK_HI && r_sync2[g] && w_done) |
                                (r_level && !(r_state == CHK_LO && !r_sync2[g] && w_done));
        assign buttons_level[g]   = r_level;
        assign buttons_press[g]   = r_press;
        assign buttons_release[g] = r_release;

        // debounce FSM: flip the level only after STABLE_COUNT consecutive differing samples
        always_ff @(posedge x1 or posedge reset) begin
            if (reset) begin
                r_state   <= STABLE_LO;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    STABLE_LO: begin
                        r_state <= r_sync2[g] ? CHK_HI : STABLE_LO;
                        r_cnt   <= r_sync2[g] ? CNT_W'(1) : '0;
                    end
                    CHK_HI: begin
                        if (!r_sync2[g]) begin
                            r_state <= STABLE_LO;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state <= STABLE_HI;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    STABLE_HI: begin
                        r_state <= r_sync2[g] ? STABLE_HI : CHK_LO;
                        r_cnt   <= r_sync2[g] ? '0 : CNT_W'(1);
                    end
                    default: begin
                        if (r_sync2[g]) begin
                            r_state <= STABLE_HI;
                            r_cnt   <= '0;
                        end else if (w_done) begin
                            r_state   <= STABLE_LO;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // any_pressed tracks the next level so it changes together with buttons_level
    always_ff @(posedge x1 or posedge reset) begin
        if (reset) any_pressed <= 1'b0;
        else       any_pressed <= |w_level_nxt;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus against a run-length debounce model
module tb_button_conditioner;
    localparam int W  = 4;
    localparam int SC = 4;

    logic         x1 = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] buttons_raw = '0;
    logic [W-1:0] buttons_level, buttons_press, buttons_release;
    logic         any_pressed;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    logic         m_any;
    int           run [W];

    button_conditioner #(.WIDTH(W), .STABLE_COUNT(SC), .CNT_W(3)) dut (
        .x1(x1), .reset(reset), .buttons_raw(buttons_raw),
        .buttons_level(buttons_level), .buttons_press(buttons_press),
        .buttons_release(buttons_release), .any_pressed(any_pressed)
    );

    always #5 x1 = ~x1;

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    // the level flips once the pin, seen two cycles late, has disagreed with it SC samples in a row
    task automatic model_step(input logic [W-1:0] raw);
        for (int i = 0; i < W; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            if (m_s2[i] != m_level[i]) begin
                run[i]++;
                if (run[i] == SC) begin
                    m_level[i] = m_s2[i];
                    m_press[i] = m_s2[i];
                    m_rel[i]   = !m_s2[i];
                    run[i]     = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        m_s2  = m_s1;
        m_s1  = raw;
        m_any = |m_level;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("level", buttons_level, m_level);
        chk("press", buttons_press, m_press);
        chk("release", buttons_release, m_rel);
        chk("any_pressed", {3'b0, any_pressed}, {3'b0, m_any});
        chk("press_and_release", buttons_press & buttons_release, '0);
    endtask

    task automatic tick(input logic [W-1:0] raw);
        buttons_raw = raw;
        @(posedge x1);
        model_step(raw);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) tick(raw);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        @(posedge x1);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge x1);
        #1;
        check_all();
        reset = 1'b0;
        hold(4'b0000, 20);
        hold(4'b0001, 10);
        tick(4'b0011); tick(4'b0001); tick(4'b0011); tick(4'b0011); tick(4'b0001);
        hold(4'b0011, 10);
        hold(4'b0111, 10);
        hold(4'b0011, 10);
        hold(4'b0000, 10);
        hold(4'b1010, 10);
        hold(4'b0000, 10);
        hold(4'b0001, 4);
        pulse_reset();
        hold(4'b0001, 10);
        hold(4'b1111, 10);
        pulse_reset();
        hold(4'b0000, 10);
        for (int n = 0; n < 1500; n++) begin
            logic [W-1:0] r;
            r = buttons_raw;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 199) == 0) pulse_reset();
            tick(r);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
